// File: rtl/vend_sequencer.sv
// Vending front-end controller: coin credit accumulation, price check and
// vend pulse, then greedy coin-by-coin change payout over a req/ack hopper
// handshake with a sticky timeout fault.
module vend_sequencer #(
    parameter int unsigned PRICE0      = 10,
    parameter int unsigned PRICE1      = 15,
    parameter int unsigned PRICE2      = 20,
    parameter int unsigned PRICE3      = 25,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    input  logic       hop_ack,
    output logic [5:0] credit,
    output logic [3:0] drink_out,
    output logic       sel_deny,
    output logic       coin_reject,
    output logic       hop_req,
    output logic [1:0] hop_coin,
    output logic       busy,
    output logic       hop_fault
);

    typedef enum logic [1:0] {
        IDLE,
        CHG_REQ,
        CHG_GAP,
        FAULT
    } state_t;

    state_t     state, state_nx;
    logic [3:0] timer, timer_nx;
    logic [5:0] credit_nx;
    logic [3:0] drink_nx;
    logic       sel_deny_nx;
    logic       coin_reject_nx;
    logic       hop_req_nx;
    logic [1:0] hop_coin_nx;
    logic       busy_nx;
    logic       fault_nx;

    logic [6:0] credit_ext;
    logic [6:0] coin_sum;
    logic [6:0] sel_price;
    logic [6:0] sel_remain;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    return 7'd1;
            2'd1:    return 7'd5;
            2'd2:    return 7'd10;
            default: return 7'd50;
        endcase
    endfunction

    function automatic logic [6:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    return 7'(PRICE0);
            2'd1:    return 7'(PRICE1);
            2'd2:    return 7'(PRICE2);
            default: return 7'(PRICE3);
        endcase
    endfunction

    // Largest denomination not exceeding the remaining credit
    function automatic logic [1:0] greedy_code(input logic [5:0] c);
        if (c >= 6'd50)      return 2'd3;
        else if (c >= 6'd10) return 2'd2;
        else if (c >= 6'd5)  return 2'd1;
        else                 return 2'd0;
    endfunction

    assign credit_ext = {1'b0, credit};
    assign coin_sum   = credit_ext + coin_value(coin_type);
    assign sel_price  = price_of(sel_id);
    assign sel_remain = credit_ext - sel_price;

    // State and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            credit      <= '0;
            drink_out   <= '0;
            sel_deny    <= 1'b0;
            coin_reject <= 1'b0;
            hop_req     <= 1'b0;
            hop_coin    <= '0;
            busy        <= 1'b0;
            hop_fault   <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            credit      <= credit_nx;
            drink_out   <= drink_nx;
            sel_deny    <= sel_deny_nx;
            coin_reject <= coin_reject_nx;
            hop_req     <= hop_req_nx;
            hop_coin    <= hop_coin_nx;
            busy        <= busy_nx;
            hop_fault   <= fault_nx;
        end
    end

    // Next-state and next-output decode; outputs are derived from the next
    // state so hop_req rises on the same edge that enters CHG_REQ
    always_comb begin
        state_nx       = state;
        timer_nx       = timer;
        credit_nx      = credit;
        drink_nx       = '0;
        sel_deny_nx    = 1'b0;
        coin_reject_nx = 1'b0;
        fault_nx       = hop_fault;

        case (state)
            IDLE: begin
                timer_nx = '0;
                if (cancel) begin
                    coin_reject_nx = coin_valid;
                    if (credit != '0) state_nx = CHG_REQ;
                end else if (sel_valid) begin
                    coin_reject_nx = coin_valid;
                    if (credit_ext >= sel_price) begin
                        drink_nx[sel_id] = 1'b1;
                        credit_nx        = sel_remain[5:0];
                        if (sel_remain != '0) state_nx = CHG_REQ;
                    end else begin
                        sel_deny_nx = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= 7'd63) credit_nx = coin_sum[5:0];
                    else                   coin_reject_nx = 1'b1;
                end
            end
            CHG_REQ: begin
                coin_reject_nx = coin_valid;
                if (hop_ack) begin
                    credit_nx = 6'(credit_ext - coin_value(hop_coin));
                    timer_nx  = '0;
                    state_nx  = CHG_GAP;
                end else if (timer == 4'(ACK_TIMEOUT - 1)) begin
                    fault_nx = 1'b1;
                    state_nx = FAULT;
                end else begin
                    timer_nx = timer + 4'd1;
                end
            end
            CHG_GAP: begin
                coin_reject_nx = coin_valid;
                state_nx       = (credit == '0) ? IDLE : CHG_REQ;
            end
            FAULT: begin
                coin_reject_nx = coin_valid;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        hop_req_nx  = (state_nx == CHG_REQ);
        hop_coin_nx = hop_req_nx ? greedy_code(credit_nx) : '0;
        busy_nx     = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: the driver pushes predicted output
// records from a credit-level model, the monitor pops one per notable cycle.
module tb_vend_sequencer;

    localparam int ACK_TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = '0;
    logic       cancel = 1'b0;
    logic       hop_ack = 1'b0;
    logic [5:0] credit;
    logic [3:0] drink_out;
    logic       sel_deny;
    logic       coin_reject;
    logic       hop_req;
    logic [1:0] hop_coin;
    logic       busy;
    logic       hop_fault;

    vend_sequencer #(
        .PRICE0(10), .PRICE1(15), .PRICE2(20), .PRICE3(25), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .hop_ack(hop_ack),
        .credit(credit), .drink_out(drink_out), .sel_deny(sel_deny),
        .coin_reject(coin_reject), .hop_req(hop_req), .hop_coin(hop_coin),
        .busy(busy), .hop_fault(hop_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] drink;
        logic       deny;
        logic       rej;
        logic [5:0] credit;
        logic       req;
        logic [1:0] coin;
        logic       busy;
        logic       fault;
        int         gap;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    int prices[4] = '{10, 15, 20, 25};
    int cvals[4]  = '{1, 5, 10, 50};
    int dseq[3]   = '{0, 1, 3};

    // Model state
    int mcredit = 0;
    bit mreq = 0;
    bit mbusy = 0;
    bit mfault = 0;

    function automatic logic [1:0] greedy(input int c);
        if (c >= 50)      return 2'd3;
        else if (c >= 10) return 2'd2;
        else if (c >= 5)  return 2'd1;
        else              return 2'd0;
    endfunction

    function automatic void push_exp(input logic [3:0] d, input bit deny, input bit rej, input int gap);
        rec_t e;
        e.drink  = d;
        e.deny   = deny;
        e.rej    = rej;
        e.credit = 6'(mcredit);
        e.req    = mreq;
        e.coin   = greedy(mcredit);
        e.busy   = mbusy;
        e.fault  = mfault;
        e.gap    = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: one record per cycle in which any output pulses or changes
    logic [5:0] pcredit = '0;
    logic       preq = 0, pbusy = 0, pfault = 0;
    logic [1:0] pcoin = '0;
    int         lowcnt = 0;

    always @(negedge clk) begin
        rec_t o, e;
        bit   hit, ok;
        o.drink  = drink_out;
        o.deny   = sel_deny;
        o.rej    = coin_reject;
        o.credit = credit;
        o.req    = hop_req;
        o.coin   = hop_coin;
        o.busy   = busy;
        o.fault  = hop_fault;
        o.gap    = (hop_req && !preq) ? lowcnt : -1;
        hit = (drink_out != 0) || sel_deny || coin_reject || (credit != pcredit) ||
              (hop_req != preq) || (busy != pbusy) || (hop_fault != pfault) ||
              (hop_req && preq && hop_coin != pcoin);
        if (mon_en && !rst && hit) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output at %0t: drink=%b deny=%b rej=%b credit=%0d req=%b coin=%0d busy=%b fault=%b",
                         $time, o.drink, o.deny, o.rej, o.credit, o.req, o.coin, o.busy, o.fault);
            end else begin
                e = exp_q.pop_front();
                ok = (o.drink === e.drink) && (o.deny === e.deny) && (o.rej === e.rej) &&
                     (o.credit === e.credit) && (o.req === e.req) && (o.busy === e.busy) &&
                     (o.fault === e.fault) && (!e.req || o.coin === e.coin) &&
                     (e.gap < 0 || o.gap == e.gap);
                if (!ok) begin
                    failures++;
                    $display("FAIL scoreboard at %0t: got drink=%b deny=%b rej=%b credit=%0d req=%b coin=%0d busy=%b fault=%b gap=%0d; expected drink=%b deny=%b rej=%b credit=%0d req=%b coin=%0d busy=%b fault=%b gap=%0d",
                             $time, o.drink, o.deny, o.rej, o.credit, o.req, o.coin, o.busy, o.fault, o.gap,
                             e.drink, e.deny, e.rej, e.credit, e.req, e.coin, e.busy, e.fault, e.gap);
                end
            end
        end
        lowcnt = hop_req ? 0 : lowcnt + 1;
        pcredit = credit;
        preq    = hop_req;
        pbusy   = busy;
        pfault  = hop_fault;
        pcoin   = hop_coin;
    end

    // One clock cycle of input stimulus, applied at the falling edge
    task automatic step(input bit cv, input logic [1:0] ct, input bit sv,
                        input logic [1:0] sid, input bit cn, input bit ack);
        @(negedge clk);
        coin_valid = cv;
        coin_type  = ct;
        sel_valid  = sv;
        sel_id     = sid;
        cancel     = cn;
        hop_ack    = ack;
    endtask

    // Pay out mcredit greedily; hang withholds ack until the timeout fault
    task automatic payout(input bit fixed, input bit hang, input bit junk);
        int n, d, c;
        bit jc;
        n = 0;
        while (mcredit > 0) begin
            d = hang ? 1000 : (fixed ? dseq[n % 3] : int'($urandom_range(0, 3)));
            c = cvals[greedy(mcredit)];
            for (int k = 0; k < ACK_TO; k++) begin
                if (k == d) begin
                    step(0, 0, 0, 0, 0, 1);
                    mcredit -= c;
                    mreq = 0;
                    push_exp(4'd0, 0, 0, -1);
                    break;
                end
                if (k == ACK_TO - 1) begin
                    step(0, 0, 0, 0, 0, 0);
                    mreq = 0;
                    mfault = 1;
                    push_exp(4'd0, 0, 0, -1);
                    return;
                end
                jc = junk && ($urandom_range(0, 2) == 0);
                step(jc, 2'($urandom_range(0, 3)), junk && $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)), junk && $urandom_range(0, 1) == 1, 0);
                if (jc) push_exp(4'd0, 0, 1, -1);
            end
            // gap cycle; a stray ack here must be ignored
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            if (mcredit > 0) begin
                mreq = 1;
                push_exp(4'd0, 0, 0, 1);
            end else begin
                mbusy = 0;
                push_exp(4'd0, 0, 0, -1);
            end
            n++;
        end
    endtask

    task automatic do_coin(input int t);
        step(1, 2'(t), 0, 0, 0, 0);
        if (mfault) push_exp(4'd0, 0, 1, -1);
        else if (mcredit + cvals[t] <= 63) begin
            mcredit += cvals[t];
            push_exp(4'd0, 0, 0, -1);
        end else push_exp(4'd0, 0, 1, -1);
    endtask

    task automatic do_sel(input int id, input bit junk);
        step(0, 0, 1, 2'(id), 0, 0);
        if (mfault) return;
        if (mcredit >= prices[id]) begin
            mcredit -= prices[id];
            if (mcredit > 0) begin
                mreq = 1;
                mbusy = 1;
            end
            push_exp(4'(1 << id), 0, 0, -1);
            payout(0, 0, junk);
        end else push_exp(4'd0, 1, 0, -1);
    endtask

    task automatic do_cancel(input bit with_sel, input bit with_coin, input bit fixed,
                             input bit hang, input bit junk);
        bit ws;
        ws = with_sel && (mcredit > 0);
        step(with_coin, 2'($urandom_range(0, 3)), ws, 2'($urandom_range(0, 3)), 1, 0);
        if (mcredit > 0) begin
            mreq = 1;
            mbusy = 1;
            push_exp(4'd0, 0, with_coin, -1);
            payout(fixed, hang, junk);
        end else if (with_coin) push_exp(4'd0, 0, 1, -1);
    endtask

    // Reset asserted between clock edges; outputs must clear at once
    task automatic async_reset(input bit expect_req);
        @(negedge clk);
        coin_valid = 0; sel_valid = 0; cancel = 0; hop_ack = 0;
        #2;
        chk("drained_before_reset", 32'(exp_q.size()), 32'd0);
        if (expect_req) chk("req_before_reset", 32'(hop_req), 32'd1);
        mon_en = 0;
        rst = 1;
        #1;
        chk("reset_hop_req", 32'(hop_req), 32'd0);
        chk("reset_credit", 32'(credit), 32'd0);
        chk("reset_outputs", 32'({credit, drink_out, sel_deny, coin_reject, hop_req,
                                  hop_coin, busy, hop_fault}), 32'd0);
        @(negedge clk);
        #2 rst = 0;
        mcredit = 0; mreq = 0; mbusy = 0; mfault = 0;
        @(negedge clk);
        mon_en = 1;
    endtask

    initial begin
        int r;
        #1 rst = 1;
        #1;
        chk("reset_state", 32'({credit, drink_out, sel_deny, coin_reject, hop_req,
                                hop_coin, busy, hop_fault}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mon_en = 1;

        // coins 1,5,10 then drink 1 with 1 unit change
        do_coin(0); do_coin(1); do_coin(2);
        do_sel(1, 0);
        // insufficient credit for drink 3
        do_coin(2);
        do_sel(3, 0);
        do_cancel(0, 0, 1, 0, 0);
        // overflow boundary at 63
        do_coin(3); do_coin(2); do_coin(1);
        do_coin(0); do_coin(0); do_coin(0); do_coin(0);
        do_cancel(0, 0, 0, 0, 0);
        // 37 units paid out with 0/1/3 ack delays and junk inputs
        do_coin(2); do_coin(2); do_coin(2); do_coin(1); do_coin(0); do_coin(0);
        do_cancel(0, 0, 1, 0, 1);
        // cancel + sel + coin together at 20, then cancel at zero credit
        do_coin(2); do_coin(2);
        do_cancel(1, 1, 0, 0, 0);
        do_cancel(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // hopper never acks: timeout fault, then coins rejected and others ignored
        do_coin(2); do_coin(1);
        do_cancel(0, 0, 0, 1, 0);
        do_coin(0);
        do_sel(0, 0);
        step(0, 0, 0, 0, 1, 1);
        do_coin(3);
        async_reset(0);
        // reset while a change coin is being requested
        do_coin(2);
        step(0, 0, 0, 0, 1, 0);
        mreq = 1; mbusy = 1;
        push_exp(4'd0, 0, 0, -1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        async_reset(1);

        // randomized traffic
        repeat (250) begin
            r = $urandom_range(0, 9);
            if (r < 5)      do_coin($urandom_range(0, 3));
            else if (r < 8) do_sel($urandom_range(0, 3), 1);
            else if (r < 9) do_cancel($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 1);
            else            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end
        do_cancel(0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
